// File: rtl/jelly_ram_singleport_accessor.sv
// Single-port RAM initiator: turns a read/write command stream into RAM cycles and
// returns read data as a stream. Read-latency stages stall through en/regcke.
`timescale 1ns/1ps

module jelly_ram_singleport_accessor #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DOUT_REGS  = 0,
  parameter int S_REGS     = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  s_cmd_we,
  input  logic [ADDR_WIDTH-1:0] s_cmd_addr,
  input  logic [DATA_WIDTH-1:0] s_cmd_data,
  input  logic                  s_cmd_valid,
  output logic                  s_cmd_ready,

  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  m_rdata_valid,
  input  logic                  m_rdata_ready,

  output logic                  ram_en,
  output logic                  ram_regcke,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,

  output logic                  busy
);

  // Handshake rule on both streams: a beat transfers on a rising clk edge where
  // valid & ready are both 1; a producer holds valid and payload stable until then.

  localparam int ENT_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  cmd_valid;

  logic v1;
  logic v2;
  logic v_last;
  logic adv_last;
  logic adv1;
  logic cmd_ok;

  generate
    if (S_REGS != 0) begin : g_skid
      // Two entries let the registered ready lag one cycle without losing a beat.
      logic [ENT_W-1:0] ent [2];
      logic [1:0]       cnt;
      logic [1:0]       cnt_next;
      logic             wr_ptr;
      logic             rd_ptr;
      logic             ready_r;
      logic             push;
      logic             pop;

      assign push      = s_cmd_valid & ready_r;
      assign cmd_valid = (cnt != 2'd0);
      assign pop       = cmd_valid & adv1;

      always_comb begin
        cnt_next = cnt + {1'b0, push} - {1'b0, pop};
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt     <= 2'd0;
          wr_ptr  <= 1'b0;
          rd_ptr  <= 1'b0;
          ready_r <= 1'b0;
        end else begin
          cnt     <= cnt_next;
          ready_r <= (cnt_next != 2'd2);
          if (push) wr_ptr <= ~wr_ptr;
          if (pop)  rd_ptr <= ~rd_ptr;
        end
      end

      always_ff @(posedge clk) begin
        if (push) ent[wr_ptr] <= {s_cmd_we, s_cmd_addr, s_cmd_data};
      end

      assign {cmd_we, cmd_addr, cmd_data} = ent[rd_ptr];
      assign s_cmd_ready = ready_r;
    end else begin : g_pass
      // run keeps the command path closed while reset is held.
      logic run;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) run <= 1'b0;
        else          run <= 1'b1;
      end

      assign cmd_we      = s_cmd_we;
      assign cmd_addr    = s_cmd_addr;
      assign cmd_data    = s_cmd_data;
      assign cmd_valid   = s_cmd_valid & run;
      assign s_cmd_ready = adv1 & run;
    end
  endgenerate

  assign v_last   = (DOUT_REGS != 0) ? v2 : v1;
  assign adv_last = ~v_last | m_rdata_ready;

  generate
    if (DOUT_REGS != 0) begin : g_oreg
      assign ram_regcke = adv_last;
      assign adv1       = ~v1 | adv_last;
    end else begin : g_noreg
      assign ram_regcke = 1'b0;
      assign adv1       = adv_last;
    end
  endgenerate

  // Writes also wait for adv1: any enabled RAM cycle overwrites the first stage.
  assign cmd_ok   = cmd_valid & adv1;
  assign ram_en   = cmd_ok;
  assign ram_we   = cmd_ok & cmd_we;
  assign ram_addr = cmd_addr;
  assign ram_din  = cmd_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (adv1)                             v1 <= cmd_ok & ~cmd_we;
      if ((DOUT_REGS != 0) && ram_regcke)   v2 <= v1;
    end
  end

  assign m_rdata_valid = v_last;
  assign m_rdata       = ram_dout;
  assign busy          = v1 | v2;

endmodule
